// File: rtl/arbitro_ram.sv
// arbitro_ram: two-requester round-robin arbiter and sequencer for the single-port
// data RAM (asynchronous read, synchronous write).
//
// Requester 0 is the CPU datapath, requester 1 the loader/debug port. Each granted
// access takes a fixed IDLE->ACC window of two cycles. All RAM control lines are
// registered. Read data is captured at the end of ACC and returned with a one-cycle
// done pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reqN/weN/dirN/datoN request, write enable, address, write data for requester N
//   gntN                one-cycle pulse: request accepted
//   doneN               one-cycle pulse: access complete (rdata valid for reads)
//   rdata               data of the last completed read (shared)
//   ram_dir/ram_datoin  RAM address / write data
//   ram_we/ram_re       RAM write / read enables
//   ram_datoout         RAM read data (asynchronous)
//
// Optional feature, enabled by defining RAM_ARB_CNT_EN:
//   cnt0, cnt1          saturating 16-bit completed-access counters per requester

module arbitro_ram #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] dir0,
    input  logic [DW-1:0] dato0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] dir1,
    input  logic [DW-1:0] dato1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_dir,
    output logic [DW-1:0] ram_datoin,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_datoout
`ifdef RAM_ARB_CNT_EN
    ,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1
`endif
);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;   // id of the most recently served requester
    logic          win_q, win_d;     // id of the requester owning the current access
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] dir_q, dir_d;
    logic [DW-1:0] datoin_q, datoin_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          win;

    // Single requester wins outright; on contention the one not served last wins.
    assign win = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        rdata_d  = rdata_q;
        dir_d    = dir_q;
        datoin_d = datoin_q;
        we_d     = 1'b0;
        re_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    win_d    = win;
                    dir_d    = win ? dir1 : dir0;
                    datoin_d = win ? dato1 : dato0;
                    we_d     = win ? we1 : we0;
                    re_d     = ~(win ? we1 : we0);
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    state_d  = StAcc;
                end
            end
            StAcc: begin
                // RAM write commits at this edge; reads are captured here.
                if (re_q) begin
                    rdata_d = ram_datoout;
                end
                done0_d = ~win_q;
                done1_d = win_q;
                last_d  = win_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata_q  <= '0;
            dir_q    <= '0;
            datoin_q <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata_q  <= rdata_d;
            dir_q    <= dir_d;
            datoin_q <= datoin_d;
            we_q     <= we_d;
            re_q     <= re_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign rdata      = rdata_q;
    assign ram_dir    = dir_q;
    assign ram_datoin = datoin_q;
    assign ram_we     = we_q;
    assign ram_re     = re_q;

`ifdef RAM_ARB_CNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // An access interrupted by rst is never counted: the reset branch wins.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (state_q == StAcc) begin
            if (!win_q && cnt0_q != 16'hFFFF) begin
                cnt0_d = cnt0_q + 16'd1;
            end
            if (win_q && cnt1_q != 16'hFFFF) begin
                cnt1_d = cnt1_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
